// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Holds the FSM encoding, PC step and reset defaults.
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

    // Word-align an address by clearing the byte offset.
    function automatic logic [31:0] align_pc(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_out_buf.sv
// One-entry valid/ready output buffer between fetch and decode.
// A flush drops the held entry, including one being loaded this cycle.
module fetch_out_buf
    import fetch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_instr,
    output logic            in_room,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_instr
);

    logic            valid_q, valid_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic            pop;

    // Next-entry computation: pop, then load, then flush wins.
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pop     = valid_q & out_ready;
        in_room = ~valid_q | pop;
        if (pop) begin
            valid_d = 1'b0;
        end
        if (in_valid) begin
            valid_d = 1'b1;
            pc_d    = in_pc;
            instr_d = in_instr;
        end
        if (flush) begin
            valid_d = 1'b0;
        end
    end

    // Entry registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign out_valid = valid_q;
    assign out_pc    = pc_q;
    assign out_instr = instr_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC sequencing, imem req/ack handshake and redirects.
// Fetched words go through a one-entry buffer towards decode.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_instr
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic            pend_q, pend_d;
    logic            req;
    logic            load;
    logic            room;
    logic [XLEN-1:0] addr;
    logic            unused_lo;

    // The byte offset of a redirect target is dropped.
    assign unused_lo = ^redirect_pc[1:0];

    // Request, pending tracking, PC sequencing and next state.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        pend_d  = pend_q;
        req     = 1'b0;
        load    = 1'b0;

        unique case (state_q)
            FETCH:   req = room | pend_q;
            STALL:   req = room;
            FLUSH:   req = pend_q;
            default: req = 1'b0;
        endcase

        // An outstanding request keeps its original address.
        addr = pend_q ? addr_q : pc_q;

        if (req) begin
            if (imem_ack) begin
                pend_d = 1'b0;
            end else begin
                pend_d = 1'b1;
                addr_d = addr;
            end
        end

        unique case (state_q)
            FETCH: begin
                if (req && imem_ack) begin
                    load = 1'b1;
                    pc_d = pc_q + PC_STEP;
                end else if (!req) begin
                    state_d = STALL;
                end
            end
            STALL: begin
                if (room) begin
                    state_d = FETCH;
                    if (imem_ack) begin
                        load = 1'b1;
                        pc_d = pc_q + PC_STEP;
                    end
                end
            end
            FLUSH: begin
                if (req && imem_ack) begin
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase

        // Redirect drops in-flight data; an unacked request must drain.
        if (redirect_valid) begin
            pc_d    = align_pc(redirect_pc);
            load    = 1'b0;
            state_d = (req && !imem_ack) ? FLUSH : FETCH;
        end
    end

    // PC, FSM and outstanding-request registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= align_pc(RESET_PC);
            addr_q  <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            pend_q  <= pend_d;
        end
    end

    assign imem_req  = req & ~reset;
    assign imem_addr = addr;

    fetch_out_buf #(
        .XLEN(XLEN)
    ) u_out_buf (
        .clk      (clk),
        .reset    (reset),
        .flush    (redirect_valid),
        .in_valid (load),
        .in_pc    (addr),
        .in_instr (imem_rdata),
        .in_room  (room),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_pc   (out_pc),
        .out_instr(out_instr)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a latency-programmable memory.
// Inputs change on the falling edge; outputs are sampled 1 before rise.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;

    logic [1:0]  lat = 2'd0;
    logic [1:0]  cnt = 2'd0;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] MASK = 32'hA5A5_0000;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .out_instr     (out_instr)
    );

    // Memory acks after req has been held for 'lat' extra cycles.
    assign imem_ack   = imem_req && (cnt >= lat);
    assign imem_rdata = imem_addr ^ MASK;

    always @(posedge clk) begin
        if (imem_req && !imem_ack) cnt <= cnt + 2'd1;
        else cnt <= 2'd0;
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One reset edge; returns at the falling edge of the first free cycle.
    task automatic do_reset(input logic [1:0] l, input logic rdy);
        @(negedge clk);
        reset          = 1'b1;
        redirect_valid = 1'b0;
        @(negedge clk);
        reset     = 1'b0;
        lat       = l;
        out_ready = rdy;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] e_vld  [7];
        logic [31:0] e_addr [7];
        logic [31:0] e_pc   [7];
        e_vld  = '{0, 0, 0, 1, 0, 0, 1};
        e_addr = '{0, 0, 0, 4, 4, 4, 8};
        e_pc   = '{0, 0, 0, 0, 0, 0, 4};

        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b1;

        // Reset state while reset is still held.
        @(negedge clk);
        #4;
        check("rst_vld", {31'd0, out_valid}, 32'd0);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_pc", out_pc, 32'd0);
        check("rst_instr", out_instr, 32'd0);

        // Zero-wait memory streams one instruction per cycle.
        @(negedge clk);
        reset = 1'b0;
        #4;
        check("zw_req", {31'd0, imem_req}, 32'd1);
        check("zw_addr", imem_addr, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #4;
            check("zw_vld", {31'd0, out_valid}, 32'd1);
            check("zw_pc", out_pc, 32'(4 * i));
            check("zw_instr", out_instr, 32'(4 * i) ^ MASK);
        end

        // Three-cycle ack latency holds the address steady.
        do_reset(2'd2, 1'b1);
        for (int t = 0; t < 7; t++) begin
            if (t > 0) @(negedge clk);
            #4;
            check("lat_vld", {31'd0, out_valid}, e_vld[t]);
            check("lat_addr", imem_addr, e_addr[t]);
            check("lat_req", {31'd0, imem_req}, 32'd1);
            if (e_vld[t][0]) check("lat_pc", out_pc, e_pc[t]);
        end

        // Decode back-pressure freezes output and stalls fetch.
        do_reset(2'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #4;
            check("st_vld", {31'd0, out_valid}, 32'd1);
            check("st_pc", out_pc, 32'd0);
            check("st_instr", out_instr, MASK);
            check("st_req", {31'd0, imem_req}, 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #4;
        check("st_resume_req", {31'd0, imem_req}, 32'd1);
        check("st_resume_addr", imem_addr, 32'd4);
        @(negedge clk);
        #4;
        check("st_next_pc", out_pc, 32'd4);
        check("st_next_vld", {31'd0, out_valid}, 32'd1);

        // Redirect while a two-cycle request to 0x8 is outstanding.
        do_reset(2'd0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        lat            = 2'd1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        #4;
        check("fl_c_addr", imem_addr, 32'd8);
        check("fl_c_ack", {31'd0, imem_ack}, 32'd0);
        check("fl_c_pc", out_pc, 32'd4);
        @(negedge clk);
        redirect_valid = 1'b0;
        lat            = 2'd0;
        #4;
        check("fl_d_req", {31'd0, imem_req}, 32'd1);
        check("fl_d_addr", imem_addr, 32'd8);
        check("fl_d_vld", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        #4;
        check("fl_e_vld", {31'd0, out_valid}, 32'd0);
        check("fl_e_addr", imem_addr, 32'h100);
        @(negedge clk);
        #4;
        check("fl_f_vld", {31'd0, out_valid}, 32'd1);
        check("fl_f_pc", out_pc, 32'h100);
        check("fl_f_instr", out_instr, 32'hA5A5_0100);

        // Redirect in the same cycle as an ack and a pop.
        do_reset(2'd0, 1'b1);
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        #4;
        check("ra_b_pc", out_pc, 32'd0);
        check("ra_b_ack", {31'd0, imem_ack}, 32'd1);
        @(negedge clk);
        redirect_valid = 1'b0;
        #4;
        check("ra_c_vld", {31'd0, out_valid}, 32'd0);
        check("ra_c_addr", imem_addr, 32'h200);
        @(negedge clk);
        #4;
        check("ra_d_vld", {31'd0, out_valid}, 32'd1);
        check("ra_d_pc", out_pc, 32'h200);
        check("ra_d_instr", out_instr, 32'hA5A5_0200);

        // Redirect to the top word, then wrap to zero.
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        #4;
        check("wr_e_pc", out_pc, 32'h204);
        @(negedge clk);
        redirect_valid = 1'b0;
        #4;
        check("wr_f_vld", {31'd0, out_valid}, 32'd0);
        check("wr_f_addr", imem_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        #4;
        check("wr_g_pc", out_pc, 32'hFFFF_FFFC);
        check("wr_g_instr", out_instr, 32'h5A5A_FFFC);
        check("wr_g_addr", imem_addr, 32'd0);
        @(negedge clk);
        #4;
        check("wr_h_pc", out_pc, 32'd0);
        check("wr_h_instr", out_instr, MASK);

        // Reset mid-stream, then restart at the reset PC.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #4;
        check("mr_vld", {31'd0, out_valid}, 32'd0);
        check("mr_req", {31'd0, imem_req}, 32'd0);
        check("mr_pc", out_pc, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #4;
        check("mr_restart_req", {31'd0, imem_req}, 32'd1);
        check("mr_restart_addr", imem_addr, 32'd0);
        @(negedge clk);
        #4;
        check("mr_first_vld", {31'd0, out_valid}, 32'd1);
        check("mr_first_pc", out_pc, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
